// File: rtl/connect4_pkg.sv
// Shared definitions for the connect-four win scanners: board defaults,
// player encoding, scanner FSM state codes and default index widths.
package connect4_pkg;

  localparam int ROWS_DEF    = 6;
  localparam int COLS_DEF    = 7;
  localparam int WIN_LEN_DEF = 4;

  localparam logic PLAYER1 = 1'b1;
  localparam logic PLAYER2 = 1'b0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int ROW_W = $clog2(ROWS_DEF);
  localparam int COL_W = $clog2(COLS_DEF);

endpackage

// File: rtl/win_run_counter.sv
// Saturating consecutive-match counter shared by the win scanners.
// hit flags the increment that completes a run of WIN_LEN, so the caller can
// finish in the same cycle the last matching cell is evaluated.
module win_run_counter
  import connect4_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic rst_run,
  output logic hit
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);

  logic [CNT_W-1:0] count_q;

  assign hit = inc && (count_q == CNT_W'(WIN_LEN - 1));

  // Run length: cleared on request, otherwise counts matches and stops at WIN_LEN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (rst_run) begin
      count_q <= '0;
    end else if (inc && (count_q != CNT_W'(WIN_LEN))) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/vertical_win_scanner.sv
// Vertical win detector: after a drop, walks the dropped-into column from the
// bottom row upward through the board store and reports whether the mover
// owns WIN_LEN consecutive cells, plus the top row of that run.
module vertical_win_scanner
  import connect4_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [$clog2(COLS)-1:0]  col,
  input  logic                     player,
  output logic                     rd_en,
  output logic [$clog2(COLS)-1:0]  rd_col,
  output logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic                     cell_occ,
  input  logic                     cell_owner,
  output logic                     busy,
  output logic                     done,
  output logic                     win,
  output logic [$clog2(ROWS)-1:0]  win_row,
  output logic                     game_won,
  input  logic                     clear
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  if ((ROWS < 2) || (WIN_LEN < 2) || (WIN_LEN > ROWS)) begin : g_bad_params
    $error("vertical_win_scanner: need ROWS >= 2 and 2 <= WIN_LEN <= ROWS");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic          player_q, player_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_q, win_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic          game_won_q;
  logic          inc, rst_run, hit;
  logic          start_acc, eval_occ;

  assign start_acc = (state_q == S_IDLE) && start;
  assign eval_occ  = (state_q == S_EVAL) && cell_occ;
  assign inc       = eval_occ && (cell_owner == player_q);
  assign rst_run   = start_acc || (eval_occ && (cell_owner != player_q));

  win_run_counter #(
    .WIN_LEN (WIN_LEN)
  ) u_run (
    .clk     (clk),
    .resetn  (resetn),
    .inc     (inc),
    .rst_run (rst_run),
    .hit     (hit)
  );

  // col_q/row_q only change on entry to READ, so they double as the read address
  assign rd_en    = (state_q == S_READ);
  assign rd_col   = col_q;
  assign rd_row   = row_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign win      = win_q;
  assign win_row  = win_row_q;
  assign game_won = game_won_q;

  // Scan sequencing: next state, latched request and result
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    player_d  = player_q;
    row_d     = row_q;
    win_d     = win_q;
    win_row_d = win_row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d    = col;
          player_d = player;
          row_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: state_d = S_EVAL;
      S_EVAL: begin
        if (!cell_occ) begin
          // pieces stack, so an empty cell ends the column
          state_d   = S_DONE;
          win_d     = 1'b0;
          win_row_d = '0;
        end else if (hit) begin
          state_d   = S_DONE;
          win_d     = 1'b1;
          win_row_d = row_q;
        end else if (row_q == RW'(ROWS - 1)) begin
          state_d   = S_DONE;
          win_d     = 1'b0;
          win_row_d = '0;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan state and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      player_q  <= 1'b0;
      row_q     <= '0;
      win_q     <= 1'b0;
      win_row_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      player_q  <= player_d;
      row_q     <= row_d;
      win_q     <= win_d;
      win_row_q <= win_row_d;
    end
  end

  // Sticky game-over flag; a new-game clear overrides a simultaneous win
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      game_won_q <= 1'b0;
    end else if (clear) begin
      game_won_q <= 1'b0;
    end else if (done && win_q) begin
      game_won_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vertical_win_scanner.sv
// Directed bench for vertical_win_scanner: a default-size instance plus an
// 8-row / 5-in-a-row instance, both reading one shared board model that
// answers reads one cycle after rd_en.
module tb_vertical_win_scanner;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [2:0] col = 3'd0;
  logic       player = 1'b0;
  logic       clear = 1'b0;
  logic       sel = 1'b0;

  logic       rd_en1, busy1, done1, win1, gw1, occ1, own1;
  logic [2:0] rd_col1, rd_row1, win_row1;
  logic       rd_en2, busy2, done2, win2, gw2, occ2, own2;
  logic [2:0] rd_col2, rd_row2, win_row2;

  logic       done_m, win_m, gw_m, busy_m;
  logic [2:0] win_row_m;

  logic occ_b [0:6][0:7];
  logic own_b [0:6][0:7];

  int cyc = 0;
  int rd_count = 0;
  int done_count = 0;
  int bad_col = 0;
  logic watch_col = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vertical_win_scanner u_dut1 (
    .clk(clk), .resetn(resetn), .start(start && !sel), .col(col), .player(player),
    .rd_en(rd_en1), .rd_col(rd_col1), .rd_row(rd_row1),
    .cell_occ(occ1), .cell_owner(own1), .busy(busy1), .done(done1),
    .win(win1), .win_row(win_row1), .game_won(gw1), .clear(clear)
  );

  vertical_win_scanner #(.ROWS(8), .COLS(7), .WIN_LEN(5)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start && sel), .col(col), .player(player),
    .rd_en(rd_en2), .rd_col(rd_col2), .rd_row(rd_row2),
    .cell_occ(occ2), .cell_owner(own2), .busy(busy2), .done(done2),
    .win(win2), .win_row(win_row2), .game_won(gw2), .clear(clear)
  );

  assign done_m    = sel ? done2 : done1;
  assign win_m     = sel ? win2 : win1;
  assign win_row_m = sel ? win_row2 : win_row1;
  assign gw_m      = sel ? gw2 : gw1;
  assign busy_m    = sel ? busy2 : busy1;

  // board store with one-cycle read latency, plus event counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en1) begin
      occ1 <= occ_b[rd_col1][rd_row1];
      own1 <= own_b[rd_col1][rd_row1];
    end
    if (rd_en2) begin
      occ2 <= occ_b[rd_col2][rd_row2];
      own2 <= own_b[rd_col2][rd_row2];
    end
    if (rd_en1 || rd_en2) rd_count <= rd_count + 1;
    if (done1 || done2) done_count <= done_count + 1;
    if (watch_col && rd_en1 && (rd_col1 !== 3'd2)) bad_col <= bad_col + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [2:0] c, input logic p, input int exp_lat,
                      input logic exp_win, input int exp_row, input int exp_reads,
                      input logic exp_gw, input logic clr);
    int t0, n, rc0, dc0;
    rc0 = rd_count;
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1; col = c; player = p;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_m !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - t0 + 1, exp_lat);
    chk("win", {31'd0, win_m}, {31'd0, exp_win});
    chk("win_row", {29'd0, win_row_m}, exp_row);
    chk("reads", rd_count - rc0, exp_reads);
    clear = clr;
    @(negedge clk);
    clear = 1'b0;
    chk("game_won", {31'd0, gw_m}, {31'd0, exp_gw});
    chk("done_single_cycle", {31'd0, done_m}, 32'd0);
    chk("busy_after", {31'd0, busy_m}, 32'd0);
    chk("done_count", done_count - dc0, 1);
    chk("win_held", {31'd0, win_m}, {31'd0, exp_win});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, n, rc0, dc0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 8; r++) begin
        occ_b[c][r] = 1'b0;
        own_b[c][r] = 1'b0;
      end
    for (int r = 0; r < 4; r++) begin occ_b[2][r] = 1'b1; own_b[2][r] = 1'b1; end
    for (int r = 0; r < 5; r++) occ_b[0][r] = 1'b1;
    own_b[0][0] = 1'b1;
    for (int r = 0; r < 6; r++) begin occ_b[1][r] = 1'b1; own_b[1][r] = (r != 3); end
    for (int r = 0; r < 8; r++) begin occ_b[3][r] = 1'b1; own_b[3][r] = (r >= 3); end

    // reset state of both instances
    repeat (3) @(negedge clk);
    chk("reset_dut1", {22'd0, rd_en1, busy1, done1, win1, gw1, rd_row1, win_row1, rd_col1} & 32'h3ff, 32'd0);
    chk("reset_dut2", {22'd0, rd_en2, busy2, done2, win2, gw2, rd_row2, win_row2, rd_col2} & 32'h3ff, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", {31'd0, busy1}, 32'd0);

    // four in a row from the bottom
    scan(3'd2, 1'b1, 9, 1'b1, 3, 4, 1'b1, 1'b0);
    // run broken at row 0, then four of player 2
    scan(3'd0, 1'b0, 11, 1'b1, 4, 5, 1'b1, 1'b0);
    chk("rd_col_after", {29'd0, rd_col1}, 32'd0);
    // empty column
    scan(3'd6, 1'b1, 3, 1'b0, 0, 1, 1'b1, 1'b0);
    chk("rd_col_empty", {29'd0, rd_col1}, 32'd6);
    // full column without a run of four
    scan(3'd1, 1'b1, 13, 1'b0, 0, 6, 1'b1, 1'b0);
    chk("rd_row_top", {29'd0, rd_row1}, 32'd5);

    // start while busy is dropped, not queued
    dc0 = done_count;
    bad_col = 0;
    watch_col = 1'b1;
    @(negedge clk);
    start = 1'b1; col = 3'd2; player = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; col = 3'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("busy_start_latency", cyc - t0 + 1, 9);
    chk("busy_start_win", {31'd0, win1}, 32'd1);
    repeat (8) @(negedge clk);
    watch_col = 1'b0;
    chk("busy_start_one_done", done_count - dc0, 1);
    chk("busy_start_rd_col", bad_col, 0);
    chk("busy_start_idle", {31'd0, busy1}, 32'd0);

    // reset asserted in the middle of a scan
    rc0 = rd_count;
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1; col = 3'd1; player = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_count - rc0 < 2 && n < 20) begin @(negedge clk); n++; end
    chk("mid_reset_reached", rd_count - rc0, 2);
    resetn = 1'b0;
    #1;
    chk("mid_reset_outputs", {22'd0, rd_en1, busy1, done1, win1, gw1, rd_row1, win_row1, rd_col1} & 32'h3ff, 32'd0);
    repeat (4) @(negedge clk);
    chk("mid_reset_no_done", done_count - dc0, 0);
    resetn = 1'b1;
    scan(3'd2, 1'b1, 9, 1'b1, 3, 4, 1'b1, 1'b0);

    // clear coinciding with done&win
    scan(3'd2, 1'b1, 9, 1'b1, 3, 4, 1'b0, 1'b1);

    // 8-row board, five in a row at rows 3..7
    sel = 1'b1;
    scan(3'd3, 1'b1, 17, 1'b1, 7, 8, 1'b1, 1'b0);
    chk("dut1_quiet", {31'd0, gw1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
